// File: rtl/psram_responder.sv
`default_nettype none
// ============================================================================
// Module   : psram_responder
// Purpose  : Serial (SPI mode 0) PSRAM device responder. Oversamples the
//            link in the sys_clk domain, decodes ce_n-framed commands
//            (0x66 Reset Enable, 0x99 Reset, 0x02 Write, 0x03 Read with a
//            24-bit address) and backs Read/Write with a small byte array.
// Options  : `define PSRAM_RESPONDER_READ_ID_EN adds command 0x9F
//            (Read ID: 24 dummy bits, then 0x0D,0x5D,0x00,0x00 repeating).
// Ports    : sys_clk, sys_reset    - clock, async active-high reset
//            psram_ce_n/clk/si     - serial link from the initiator
//            psram_so, psram_so_oe - serial data out and its enable
//            cmd_valid, cmd_byte   - command byte strobe and held value
//            reset_armed           - a clean 0x66 frame has been seen
//            reset_pulse           - 0x66 -> 0x99 sequence detected
//            busy                  - frame in progress
// Revision : 1.0 - initial release
// ============================================================================
module psram_responder #(
  parameter int ADDR_BITS   = 6,
  parameter int SYNC_STAGES = 2   // minimum 2
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       psram_ce_n,
  input  logic       psram_clk,
  input  logic       psram_si,
  output logic       psram_so,
  output logic       psram_so_oe,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       reset_armed,
  output logic       reset_pulse,
  output logic       busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  // Only the address LSBs and a full byte are ever needed from the shifter.
  localparam int SW    = (ADDR_BITS > 8) ? ADDR_BITS : 8;

  localparam logic [7:0] CMD_RST_EN = 8'h66;
  localparam logic [7:0] CMD_RST    = 8'h99;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
`ifdef PSRAM_RESPONDER_READ_ID_EN
  localparam logic [7:0] CMD_RDID   = 8'h9F;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WADDR  = 3'd2,
    ST_RADDR  = 3'd3,
    ST_WDATA  = 3'd4,
    ST_RDATA  = 3'd5,
    ST_IGNORE = 3'd6
`ifdef PSRAM_RESPONDER_READ_ID_EN
    ,
    ST_RIDA   = 3'd7
`endif
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------
  // The ce_n chain resets to 0 ("inside a frame") so that a frame already
  // in flight when reset releases never produces a false ce_fall; a start
  // is only accepted after ce_n has genuinely been seen high.
  logic [SYNC_STAGES-1:0] ce_sync_q, clk_sync_q, si_sync_q;
  logic                   ce_prev_q, clk_prev_q;

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      ce_sync_q  <= '0;
      clk_sync_q <= '0;
      si_sync_q  <= '0;
      ce_prev_q  <= 1'b0;
      clk_prev_q <= 1'b0;
    end else begin
      ce_sync_q  <= {ce_sync_q[SYNC_STAGES-2:0], psram_ce_n};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], psram_clk};
      si_sync_q  <= {si_sync_q[SYNC_STAGES-2:0], psram_si};
      ce_prev_q  <= ce_sync_q[SYNC_STAGES-1];
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  logic ce_s, clk_s, si_s;
  logic clk_rise, clk_fall, ce_rise, ce_fall;

  assign ce_s     = ce_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign si_s     = si_sync_q[SYNC_STAGES-1];
  assign clk_rise =  clk_s & ~clk_prev_q;
  assign clk_fall = ~clk_s &  clk_prev_q;
  assign ce_rise  =  ce_s  & ~ce_prev_q;
  assign ce_fall  = ~ce_s  &  ce_prev_q;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [4:0]             bitcnt_q, bitcnt_d;
  logic [SW-2:0]          shift_q, shift_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [7:0]             rd_shift_q, rd_shift_d;
  logic                   so_q, so_d;
  logic                   so_oe_q, so_oe_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [7:0]             cmd_byte_q, cmd_byte_d;
  logic                   armed_q, armed_d;
  logic                   pending_q, pending_d;   // 0x66 done, no bits since
  logic                   pulse_q, pulse_d;
  logic                   frame_ok_q, frame_ok_d; // ce_n seen high since reset
`ifdef PSRAM_RESPONDER_READ_ID_EN
  logic                   rid_q, rid_d;           // data phase streams ID
  logic [1:0]             id_idx_q, id_idx_d;
`endif

  logic [7:0]             mem_q [DEPTH];
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [7:0]             mem_wdata;

  logic [SW-1:0]          shift_in;
  logic [ADDR_BITS-1:0]   addr_next;

  assign shift_in  = {shift_q, si_s};
  assign addr_next = addr_q + 1'b1;   // wraps DEPTH-1 -> 0 by width

`ifdef PSRAM_RESPONDER_READ_ID_EN
  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = 8'h0D;
      2'd1:    id_byte = 8'h5D;
      default: id_byte = 8'h00;
    endcase
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    rd_shift_d  = rd_shift_q;
    so_d        = so_q;
    so_oe_d     = so_oe_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    armed_d     = armed_q;
    pending_d   = pending_q;
    pulse_d     = 1'b0;
    frame_ok_d  = frame_ok_q | ce_s;
    mem_we      = 1'b0;
    mem_waddr   = addr_q;
    mem_wdata   = shift_in[7:0];
`ifdef PSRAM_RESPONDER_READ_ID_EN
    rid_d       = rid_q;
    id_idx_d    = id_idx_q;
`endif

    if (ce_fall && frame_ok_q) begin
      // Fresh frame; also recovers from a ce_fall seen outside IDLE.
      state_d   = ST_CMD;
      bitcnt_d  = 5'd0;
      shift_d   = '0;
      pending_d = 1'b0;
      so_d      = 1'b0;
      so_oe_d   = 1'b0;
    end else begin
      case (state_q)
        ST_CMD: begin
          if (clk_rise) begin
            shift_d  = shift_in[SW-2:0];
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d    = 5'd0;
              cmd_valid_d = 1'b1;
              cmd_byte_d  = shift_in[7:0];
              case (shift_in[7:0])
                CMD_RST_EN: begin
                  state_d   = ST_IGNORE;
                  pending_d = 1'b1;
                end
                CMD_RST: begin
                  state_d = ST_IGNORE;
                  pulse_d = armed_q;
                end
                CMD_WRITE: state_d = ST_WADDR;
                CMD_READ:  state_d = ST_RADDR;
`ifdef PSRAM_RESPONDER_READ_ID_EN
                CMD_RDID:  state_d = ST_RIDA;
`endif
                default:   state_d = ST_IGNORE;
              endcase
            end
          end
        end

        ST_WADDR, ST_RADDR: begin
          if (clk_rise) begin
            shift_d  = shift_in[SW-2:0];
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd23) begin
              bitcnt_d = 5'd0;
              addr_d   = shift_in[ADDR_BITS-1:0];
              if (state_q == ST_WADDR) begin
                state_d = ST_WDATA;
              end else begin
                state_d    = ST_RDATA;
                rd_shift_d = mem_q[shift_in[ADDR_BITS-1:0]];
`ifdef PSRAM_RESPONDER_READ_ID_EN
                rid_d      = 1'b0;
`endif
              end
            end
          end
        end

`ifdef PSRAM_RESPONDER_READ_ID_EN
        ST_RIDA: begin
          if (clk_rise) begin
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd23) begin
              bitcnt_d   = 5'd0;
              state_d    = ST_RDATA;
              rid_d      = 1'b1;
              id_idx_d   = 2'd0;
              rd_shift_d = id_byte(2'd0);
            end
          end
        end
`endif

        ST_WDATA: begin
          if (clk_rise) begin
            shift_d  = shift_in[SW-2:0];
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d  = 5'd0;
              mem_we    = 1'b1;
              mem_waddr = addr_q;
              mem_wdata = shift_in[7:0];
              addr_d    = addr_next;
            end
          end
        end

        ST_RDATA: begin
          if (clk_fall) begin
            so_oe_d    = 1'b1;
            so_d       = rd_shift_q[7];
            rd_shift_d = {rd_shift_q[6:0], 1'b0};
            bitcnt_d   = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d   = 5'd0;
`ifdef PSRAM_RESPONDER_READ_ID_EN
              if (rid_q) begin
                id_idx_d   = id_idx_q + 2'd1;
                rd_shift_d = id_byte(id_idx_q + 2'd1);
              end else begin
                addr_d     = addr_next;
                rd_shift_d = mem_q[addr_next];
              end
`else
              addr_d     = addr_next;
              rd_shift_d = mem_q[addr_next];
`endif
            end
          end
        end

        ST_IGNORE: begin
          // Any bit after a 0x66 disqualifies the frame from arming.
          if (clk_rise) pending_d = 1'b0;
        end

        default: ;
      endcase

      // Frame end is applied after the bit work above, so a byte that
      // completes in the same cycle still counts.
      if (ce_rise) begin
        state_d  = ST_IDLE;
        bitcnt_d = 5'd0;
        so_d     = 1'b0;
        so_oe_d  = 1'b0;
        armed_d  = pending_d;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 5'd0;
      shift_q     <= '0;
      addr_q      <= '0;
      rd_shift_q  <= 8'h00;
      so_q        <= 1'b0;
      so_oe_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'h00;
      armed_q     <= 1'b0;
      pending_q   <= 1'b0;
      pulse_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
`ifdef PSRAM_RESPONDER_READ_ID_EN
      rid_q       <= 1'b0;
      id_idx_q    <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      rd_shift_q  <= rd_shift_d;
      so_q        <= so_d;
      so_oe_q     <= so_oe_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      armed_q     <= armed_d;
      pending_q   <= pending_d;
      pulse_q     <= pulse_d;
      frame_ok_q  <= frame_ok_d;
`ifdef PSRAM_RESPONDER_READ_ID_EN
      rid_q       <= rid_d;
      id_idx_q    <= id_idx_d;
`endif
    end
  end

  // Array contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign psram_so    = so_q;
  assign psram_so_oe = so_oe_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
  assign reset_armed = armed_q;
  assign reset_pulse = pulse_q;
  assign busy        = ~ce_s & frame_ok_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_responder
// Purpose  : Directed self-checking bench for psram_responder. Drives the
//            serial link at 1/16 of sys_clk and checks command decode,
//            reset sequencing, write/read, address wrap, partial bytes and
//            mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psram_responder;

  logic       sys_clk = 1'b0;
  logic       sys_reset = 1'b1;
  logic       psram_ce_n = 1'b1;
  logic       psram_clk = 1'b0;
  logic       psram_si = 1'b0;
  logic       psram_so, psram_so_oe, cmd_valid, reset_armed, reset_pulse, busy;
  logic [7:0] cmd_byte;

  psram_responder #(.ADDR_BITS(6), .SYNC_STAGES(2)) dut (
    .sys_clk     (sys_clk),
    .sys_reset   (sys_reset),
    .psram_ce_n  (psram_ce_n),
    .psram_clk   (psram_clk),
    .psram_si    (psram_si),
    .psram_so    (psram_so),
    .psram_so_oe (psram_so_oe),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .reset_armed (reset_armed),
    .reset_pulse (reset_pulse),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass = 0;
  int n_checks = 0;
  int cv_cnt = 0;
  int rp_cnt = 0;
  logic last_so, last_oe, oe_or, oe_and;

  always @(posedge sys_clk) begin
    if (cmd_valid === 1'b1) cv_cnt++;
    if (reset_pulse === 1'b1) rp_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // One SPI mode-0 clock: SI set while clk low, SO sampled just before rise.
  task automatic clk_bit(input logic b);
    psram_si = b;
    wait_cyc(8);
    last_so = psram_so;
    last_oe = psram_so_oe;
    oe_or   = oe_or | last_oe;
    oe_and  = oe_and & last_oe;
    psram_clk = 1'b1;
    wait_cyc(8);
    psram_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) clk_bit(v[i]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) clk_bit(a[i]);
  endtask

  task automatic read_byte(output logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b0);
      v[i] = last_so;
    end
  endtask

  task automatic frame_start;
    psram_ce_n = 1'b0;
    oe_or  = 1'b0;
    oe_and = 1'b1;
    wait_cyc(8);
  endtask

  task automatic frame_end;
    wait_cyc(4);
    psram_ce_n = 1'b1;
    wait_cyc(12);
  endtask

  task automatic write_frame(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1);
    frame_start;
    send_byte(8'h02);
    send_addr(a);
    send_byte(d0);
    send_byte(d1);
    frame_end;
  endtask

  initial begin
    logic [7:0] rd0, rd1;
    int cv_base, rp_base;

    // ---------------- reset state ----------------
    wait_cyc(3);
    chk("rst_so",     psram_so,    0);
    chk("rst_oe",     psram_so_oe, 0);
    chk("rst_cv",     cmd_valid,   0);
    chk("rst_cbyte",  cmd_byte,    0);
    chk("rst_armed",  reset_armed, 0);
    chk("rst_pulse",  reset_pulse, 0);
    chk("rst_busy",   busy,        0);
    sys_reset = 1'b0;
    wait_cyc(10);

    // ---------------- 0x66 then 0x99 ----------------
    frame_start;
    chk("busy_in_frame", busy, 1);
    send_byte(8'h66);
    frame_end;
    chk("f66_cv_cnt", cv_cnt, 1);
    chk("f66_cbyte",  cmd_byte, 8'h66);
    chk("f66_armed",  reset_armed, 1);
    chk("f66_busy",   busy, 0);
    frame_start;
    send_byte(8'h99);
    frame_end;
    chk("f99_cv_cnt", cv_cnt, 2);
    chk("f99_cbyte",  cmd_byte, 8'h99);
    chk("f99_rp_cnt", rp_cnt, 1);
    chk("f99_armed",  reset_armed, 0);

    // ---------------- 0x99 alone: no pulse ----------------
    frame_start;
    send_byte(8'h99);
    frame_end;
    chk("lone99_rp_cnt", rp_cnt, 1);

    // ---------------- 0x66 + 0x02 then 0x99: no pulse ----------------
    frame_start;
    send_byte(8'h66);
    send_byte(8'h02);
    frame_end;
    chk("f66x_armed", reset_armed, 0);
    frame_start;
    send_byte(8'h99);
    frame_end;
    chk("f66x_99_rp_cnt", rp_cnt, 1);
    chk("cv_cnt_5", cv_cnt, 5);

    // ---------------- write/read at 0x000005 ----------------
    write_frame(24'h000005, 8'hA5, 8'h3C);
    frame_start;
    send_byte(8'h03);
    send_addr(24'h000005);
    chk("rd_oe_addr_phase", oe_or, 0);
    oe_and = 1'b1;
    read_byte(rd0);
    read_byte(rd1);
    chk("rd_oe_data_phase", oe_and, 1);
    chk("rd_byte0", rd0, 8'hA5);
    chk("rd_byte1", rd1, 8'h3C);
    frame_end;
    chk("rd_oe_after", psram_so_oe, 0);
    chk("rd_so_after", psram_so, 0);
    chk("rd_cbyte", cmd_byte, 8'h03);

    // ---------------- address wrap ----------------
    write_frame(24'h00003F, 8'h11, 8'h22);
    frame_start;
    send_byte(8'h03);
    send_addr(24'h000000);
    read_byte(rd0);
    frame_end;
    chk("wrap_wr_addr0", rd0, 8'h22);
    frame_start;
    send_byte(8'h03);
    send_addr(24'h00003F);
    read_byte(rd0);
    read_byte(rd1);
    frame_end;
    chk("wrap_rd_3f", rd0, 8'h11);
    chk("wrap_rd_00", rd1, 8'h22);

    // ---------------- partial write byte discarded ----------------
    write_frame(24'h000010, 8'h5A, 8'hC3);
    frame_start;
    send_byte(8'h02);
    send_addr(24'h000010);
    for (int i = 0; i < 5; i++) clk_bit(1'b1);
    frame_end;
    frame_start;
    send_byte(8'h03);
    send_addr(24'h000010);
    read_byte(rd0);
    read_byte(rd1);
    frame_end;
    chk("partial_byte0", rd0, 8'h5A);
    chk("partial_byte1", rd1, 8'hC3);

    // ---------------- reset mid-read ----------------
    frame_start;
    send_byte(8'h66);
    frame_end;
    chk("pre_rst_armed", reset_armed, 1);
    frame_start;
    send_byte(8'h03);
    send_addr(24'h000005);
    for (int i = 0; i < 3; i++) clk_bit(1'b0);
    wait_cyc(6);
    chk("midrd_oe_before", psram_so_oe, 1);
    cv_base = cv_cnt;
    rp_base = rp_cnt;
    sys_reset = 1'b1;
    wait_cyc(1);
    chk("midrd_oe",    psram_so_oe, 0);
    chk("midrd_so",    psram_so,    0);
    chk("midrd_cv",    cmd_valid,   0);
    chk("midrd_cbyte", cmd_byte,    0);
    chk("midrd_armed", reset_armed, 0);
    chk("midrd_pulse", reset_pulse, 0);
    chk("midrd_busy",  busy,        0);
    wait_cyc(2);
    sys_reset = 1'b0;
    // Rest of the interrupted frame must be ignored (0x99 pattern here).
    send_byte(8'h99);
    send_byte(8'h03);
    chk("midrd_ignored_oe", psram_so_oe, 0);
    frame_end;
    chk("midrd_ignored_cv", cv_cnt - cv_base, 0);
    chk("midrd_ignored_rp", rp_cnt - rp_base, 0);
    frame_start;
    send_byte(8'h66);
    frame_end;
    chk("post_rst_cv",    cv_cnt - cv_base, 1);
    chk("post_rst_cbyte", cmd_byte, 8'h66);
    chk("post_rst_armed", reset_armed, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #3_000_000;
    $display("FAIL timeout: observed no finish, required finish before 3ms");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
